poly_horner_eval: RTL and testbench

Consumer end of the coefficient stream produced by the Lagrange interpolator. Captures `npoints` coefficients, low degree first (c0, c1, …, c_{n-1}), from a c_wren/c_data write stream into a local buffer. On a rising edge of `en` it evaluates p(r) = sum c_k·r^k over the field using Horner's rule with one multi-cycle field_multiplier. Used on the verifier side to check prover-sent polynomials at a random point.

---
 rtl/poly_eval_pkg.sv | 35 +++
 rtl/field_multiplier.sv | 56 +++++
 rtl/poly_coeff_buf.sv | 49 ++++
 rtl/poly_horner_eval.sv | 174 +++++++++++++++++
 tb/tb_poly_horner_eval.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/poly_eval_pkg.sv
// Shared definitions for the Horner evaluator: field constants, FSM states,
// counter-width helpers and the single-subtract field adder.
package poly_eval_pkg;

    localparam int unsigned F_NBITS = 16;
    // Largest prime below 2^16.
    localparam logic [F_NBITS-1:0] F_PRIME = 16'd65521;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_ADD,
        ST_DONE
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Both operands must already be reduced, so one conditional subtract suffices.
    function automatic logic [F_NBITS-1:0] field_add(input logic [F_NBITS-1:0] a,
                                                     input logic [F_NBITS-1:0] b);
        logic [F_NBITS:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, F_PRIME}) begin
            s = s - {1'b0, F_PRIME};
        end
        return s[F_NBITS-1:0];
    endfunction

endpackage

// File: rtl/field_multiplier.sv
// Multi-cycle modular multiplier: MSB-first double-and-add over b, one bit per cycle.
// en is honoured only while ready; the product stays on out until the next en.
module field_multiplier
    import poly_eval_pkg::*;
(
    input  logic               clk,
    input  logic               rstb,
    input  logic               en,
    input  logic [F_NBITS-1:0] a,
    input  logic [F_NBITS-1:0] b,
    output logic [F_NBITS-1:0] out,
    output logic               ready
);

    localparam int unsigned BitW = $clog2(F_NBITS);

    logic               busy_q;
    logic [F_NBITS-1:0] a_q;
    logic [F_NBITS-1:0] b_q;
    logic [F_NBITS-1:0] acc_q;
    logic [F_NBITS-1:0] acc_next;
    logic [BitW-1:0]    bit_q;

    always_comb begin
        acc_next = field_add(field_add(acc_q, acc_q), b_q[bit_q] ? a_q : '0);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            busy_q <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            bit_q  <= '0;
        end else if (!busy_q) begin
            if (en) begin
                a_q    <= a;
                b_q    <= b;
                acc_q  <= '0;
                bit_q  <= BitW'(F_NBITS - 1);
                busy_q <= 1'b1;
            end
        end else begin
            acc_q <= acc_next;
            if (bit_q == '0) begin
                busy_q <= 1'b0;
            end else begin
                bit_q <= bit_q - 1'b1;
            end
        end
    end

    assign out   = acc_q;
    assign ready = ~busy_q;

endmodule

// File: rtl/poly_coeff_buf.sv
// Coefficient store: sequential write port driven by the fill count, combinational read by
// index. Owns count/full; contents are not reset.
module poly_coeff_buf
    import poly_eval_pkg::*;
#(
    parameter int unsigned npoints = 3,
    localparam int unsigned CntW = cnt_width(npoints),
    localparam int unsigned IdxW = idx_width(npoints)
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic               wren,
    input  logic               restart,
    input  logic [F_NBITS-1:0] wdata,
    input  logic               clear,
    input  logic [IdxW-1:0]    rd_idx,
    output logic [F_NBITS-1:0] rdata,
    output logic [CntW-1:0]    count,
    output logic               full
);

    logic [F_NBITS-1:0] mem [npoints];
    logic [CntW-1:0]    count_q;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            count_q <= '0;
        end else if (restart) begin
            count_q <= CntW'(1);
        end else if (wren) begin
            count_q <= count_q + 1'b1;
        end else if (clear) begin
            count_q <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (restart) begin
            mem[0] <= wdata;
        end else if (wren) begin
            mem[IdxW'(count_q)] <= wdata;
        end
    end

    assign rdata = (32'(rd_idx) < npoints) ? mem[rd_idx] : '0;
    assign count = count_q;
    assign full  = (32'(count_q) == npoints);

endmodule

// File: rtl/poly_horner_eval.sv
// Evaluates p(r) = sum c_k r^k from a captured coefficient stream using Horner's rule.
// POLY_EVAL_RETAIN_EN keeps coefficients across evaluations; a write while full restarts capture.
module poly_horner_eval
    import poly_eval_pkg::*;
#(
    parameter int unsigned npoints = 3
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic               c_wren,
    input  logic [F_NBITS-1:0] c_data,
    input  logic               en,
    input  logic [F_NBITS-1:0] r,
    output logic [F_NBITS-1:0] out,
    output logic               ready,
    output logic               ready_pulse,
    output logic               full,
    output logic               err
);

    localparam int unsigned CntW = cnt_width(npoints);
    localparam int unsigned IdxW = idx_width(npoints);

    if (npoints == 0) begin : g_bad_npoints
        $error("poly_horner_eval: npoints must be at least 1");
    end

    state_e             state_q, state_d;
    logic [F_NBITS-1:0] acc_q, acc_d;
    logic [IdxW-1:0]    idx_q, idx_d;
    logic [F_NBITS-1:0] out_q, out_d;
    logic               err_q, err_d;
    logic               mul_en_q, mul_en_d;
    logic               en_dly_q;
    logic               ready_dly_q;

    logic               in_idle;
    logic               start;
    logic               accept_wr;
    logic               restart_wr;
    logic               drop_wr;
    logic               clear_cnt;
    logic [IdxW-1:0]    rd_idx;
    logic [F_NBITS-1:0] rdata;
    logic [CntW-1:0]    count;
    logic               mul_ready;
    logic [F_NBITS-1:0] mul_out;
    logic [F_NBITS-1:0] sum;

    assign in_idle   = (state_q == ST_IDLE);
    assign start     = en & ~en_dly_q;
    assign accept_wr = c_wren & in_idle & ~full;

`ifdef POLY_EVAL_RETAIN_EN
    assign restart_wr = c_wren & in_idle & full;
    assign drop_wr    = c_wren & ~in_idle;
`else
    assign restart_wr = 1'b0;
    assign drop_wr    = c_wren & (~in_idle | full);
`endif

    // In idle the read port presents the top coefficient to seed the accumulator.
    assign rd_idx = in_idle ? IdxW'(npoints - 1) : idx_q;
    assign sum    = field_add(mul_out, rdata);

    poly_coeff_buf #(
        .npoints (npoints)
    ) u_buf (
        .clk     (clk),
        .rstb    (rstb),
        .wren    (accept_wr),
        .restart (restart_wr),
        .wdata   (c_data),
        .clear   (clear_cnt),
        .rd_idx  (rd_idx),
        .rdata   (rdata),
        .count   (count),
        .full    (full)
    );

    field_multiplier u_mul (
        .clk   (clk),
        .rstb  (rstb),
        .en    (mul_en_q),
        .a     (acc_q),
        .b     (r),
        .out   (mul_out),
        .ready (mul_ready)
    );

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        out_d     = out_q;
        mul_en_d  = 1'b0;
        err_d     = err_q;
        clear_cnt = 1'b0;

        if (drop_wr || (start && in_idle && !full)) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start && full) begin
                    if (npoints == 1) begin
                        out_d   = rdata;
                        state_d = ST_DONE;
                    end else begin
                        acc_d    = rdata;
                        idx_d    = IdxW'(npoints - 2);
                        mul_en_d = 1'b1;
                        state_d  = ST_MUL;
                    end
                end
            end
            ST_MUL: begin
                // mul_ready is still high on the issue cycle, so skip it.
                if (!mul_en_q && mul_ready) begin
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                acc_d = sum;
                if (idx_q == '0) begin
                    out_d   = sum;
                    state_d = ST_DONE;
                end else begin
                    idx_d    = idx_q - 1'b1;
                    mul_en_d = 1'b1;
                    state_d  = ST_MUL;
                end
            end
            ST_DONE: begin
`ifdef POLY_EVAL_RETAIN_EN
                clear_cnt = 1'b0;
`else
                clear_cnt = 1'b1;
`endif
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            idx_q       <= '0;
            out_q       <= '0;
            err_q       <= 1'b0;
            mul_en_q    <= 1'b0;
            en_dly_q    <= 1'b1;
            ready_dly_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            out_q       <= out_d;
            err_q       <= err_d;
            mul_en_q    <= mul_en_d;
            en_dly_q    <= en;
            ready_dly_q <= ready;
        end
    end

    assign ready       = ~start & in_idle;
    assign ready_pulse = ready & ~ready_dly_q;
    assign out         = out_q;
    assign err         = err_q;

endmodule

// File: tb/tb_poly_horner_eval.sv
// Directed bench for poly_horner_eval with npoints=3 and npoints=1 instances over p=65521.
module tb_poly_horner_eval;
    import poly_eval_pkg::*;

    logic               clk = 1'b0;
    logic               rstb = 1'b0;
    logic               c_wren = 1'b0;
    logic [F_NBITS-1:0] c_data = '0;
    logic               en = 1'b0;
    logic [F_NBITS-1:0] r = '0;
    logic [F_NBITS-1:0] out;
    logic               ready, ready_pulse, full, err;

    logic               c_wren1 = 1'b0;
    logic [F_NBITS-1:0] c_data1 = '0;
    logic               en1 = 1'b0;
    logic [F_NBITS-1:0] out1;
    logic               ready1, ready_pulse1, full1, err1;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    poly_horner_eval #(.npoints(3)) dut (
        .clk (clk), .rstb (rstb), .c_wren (c_wren), .c_data (c_data), .en (en), .r (r),
        .out (out), .ready (ready), .ready_pulse (ready_pulse), .full (full), .err (err)
    );

    poly_horner_eval #(.npoints(1)) dut1 (
        .clk (clk), .rstb (rstb), .c_wren (c_wren1), .c_data (c_data1), .en (en1), .r (r),
        .out (out1), .ready (ready1), .ready_pulse (ready_pulse1), .full (full1),
        .err (err1)
    );

    task automatic do_reset();
        @(negedge clk);
        rstb = 1'b0; c_wren = 1'b0; en = 1'b0; c_wren1 = 1'b0; en1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
    endtask

    task automatic write_coef(input bit sel, input logic [F_NBITS-1:0] v);
        @(negedge clk);
        if (sel) begin c_wren1 = 1'b1; c_data1 = v; end
        else begin c_wren = 1'b1; c_data = v; end
        @(negedge clk);
        c_wren = 1'b0;
        c_wren1 = 1'b0;
    endtask

    // Fixed 100-cycle window: captures out at the first ready_pulse and counts all pulses.
    task automatic run_eval(input bit sel, input logic [F_NBITS-1:0] rr,
                            output logic [F_NBITS-1:0] value, output int pulses,
                            output int first, output bit saw_mul);
        @(negedge clk);
        r = rr;
        if (sel) en1 = 1'b1; else en = 1'b1;
        pulses = 0; first = -1; value = '0; saw_mul = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            en = 1'b0;
            en1 = 1'b0;
            if (dut1.mul_en_q) saw_mul = 1'b1;
            if (sel ? ready_pulse1 : ready_pulse) begin
                pulses++;
                if (first < 0) begin
                    first = i;
                    value = sel ? out1 : out;
                end
            end
        end
    endtask

    task automatic test_reset();
        total++; if (out !== '0) $display("FAIL reset_out: got %0d want 0", out); else passed++;
        total++; if (ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready);
        else passed++;
        total++; if (ready_pulse !== 1'b0) $display("FAIL reset_pulse: got %b want 0", ready_pulse);
        else passed++;
        total++; if (full !== 1'b0) $display("FAIL reset_full: got %b want 0", full); else passed++;
        total++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else passed++;
    endtask

    task automatic eval_check(input string name, input logic [F_NBITS-1:0] rr,
                              input logic [F_NBITS-1:0] want);
        logic [F_NBITS-1:0] v; int p, f; bit m;
        write_coef(1'b0, 16'd1); write_coef(1'b0, 16'd2); write_coef(1'b0, 16'd3);
        run_eval(1'b0, rr, v, p, f, m);
        total++; if (v !== want) $display("FAIL %s_out: got %0d want %0d", name, v, want);
        else passed++;
        total++; if (p !== 1) $display("FAIL %s_pulses: got %0d want 1", name, p); else passed++;
    endtask

    task automatic test_eval_r5();
        logic [F_NBITS-1:0] v; int p, f; bit m;
        write_coef(1'b0, 16'd1); write_coef(1'b0, 16'd2); write_coef(1'b0, 16'd3);
        total++; if (full !== 1'b1) $display("FAIL r5_full: got %b want 1", full); else passed++;
        run_eval(1'b0, 16'd5, v, p, f, m);
        total++; if (v !== 16'd86) $display("FAIL r5_out: got %0d want 86", v); else passed++;
        total++; if (p !== 1) $display("FAIL r5_pulses: got %0d want 1", p); else passed++;
        total++; if (err !== 1'b0) $display("FAIL r5_err: got %b want 0", err); else passed++;
    endtask

    task automatic test_npoints1();
        logic [F_NBITS-1:0] v; int p, f; bit m;
        write_coef(1'b1, 16'd7);
        run_eval(1'b1, 16'd5, v, p, f, m);
        total++; if (v !== 16'd7) $display("FAIL n1_out: got %0d want 7", v); else passed++;
        total++; if (f < 1 || f > 3) $display("FAIL n1_latency: got %0d want 1..3", f);
        else passed++;
        total++; if (m !== 1'b0) $display("FAIL n1_mul_en: got %b want 0", m); else passed++;
        total++; if (p !== 1) $display("FAIL n1_pulses: got %0d want 1", p); else passed++;
    endtask

    task automatic test_partial();
        do_reset();
        write_coef(1'b0, 16'd1); write_coef(1'b0, 16'd2);
        @(negedge clk); r = 16'd5; en = 1'b1;
        @(negedge clk); en = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (ready !== 1'b1) $display("FAIL partial_ready: got %b want 1", ready);
        else passed++;
        total++; if (err !== 1'b1) $display("FAIL partial_err: got %b want 1", err); else passed++;
        total++; if (full !== 1'b0) $display("FAIL partial_full: got %b want 0", full);
        else passed++;
        total++; if (out !== '0) $display("FAIL partial_out: got %0d want 0", out); else passed++;
    endtask

    task automatic test_overflow();
        logic [F_NBITS-1:0] v; int p, f; bit m;
        do_reset();
        write_coef(1'b0, 16'd1); write_coef(1'b0, 16'd2); write_coef(1'b0, 16'd3);
        write_coef(1'b0, 16'd9);
`ifdef POLY_EVAL_RETAIN_EN
        total++; if (err !== 1'b0) $display("FAIL restart_err: got %b want 0", err); else passed++;
        total++; if (full !== 1'b0) $display("FAIL restart_full: got %b want 0", full);
        else passed++;
`else
        total++; if (err !== 1'b1) $display("FAIL overflow_err: got %b want 1", err); else passed++;
        run_eval(1'b0, 16'd5, v, p, f, m);
        total++; if (v !== 16'd86) $display("FAIL overflow_out: got %0d want 86", v);
        else passed++;
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        write_coef(1'b0, 16'd1); write_coef(1'b0, 16'd2); write_coef(1'b0, 16'd3);
        @(negedge clk); r = 16'd5; en = 1'b1;
        @(negedge clk); en = 1'b0;
        repeat (5) @(negedge clk);
        rstb = 1'b0;
        #1;
        test_reset();
        @(negedge clk); rstb = 1'b1;
        eval_check("refill_r2", 16'd2, 16'd17);
    endtask

`ifdef POLY_EVAL_RETAIN_EN
    task automatic test_retain();
        logic [F_NBITS-1:0] v; int p, f; bit m;
        do_reset();
        write_coef(1'b0, 16'd1); write_coef(1'b0, 16'd2); write_coef(1'b0, 16'd3);
        run_eval(1'b0, 16'd5, v, p, f, m);
        total++; if (v !== 16'd86) $display("FAIL retain_r5: got %0d want 86", v); else passed++;
        run_eval(1'b0, 16'd2, v, p, f, m);
        total++; if (v !== 16'd17) $display("FAIL retain_r2: got %0d want 17", v); else passed++;
        write_coef(1'b0, 16'd4); write_coef(1'b0, 16'd0); write_coef(1'b0, 16'd0);
        run_eval(1'b0, 16'd9, v, p, f, m);
        total++; if (v !== 16'd4) $display("FAIL retain_r9: got %0d want 4", v); else passed++;
        total++; if (err !== 1'b0) $display("FAIL retain_err: got %b want 0", err); else passed++;
    endtask
`endif

    initial begin
        rstb = 1'b0;
        #22;
        test_reset();
        @(negedge clk); rstb = 1'b1;
        test_eval_r5();
        eval_check("r0", 16'd0, 16'd1);
        eval_check("rpm1", F_PRIME - 16'd1, 16'd2);
        test_npoints1();
        test_partial();
        test_overflow();
        test_reset_mid();
`ifdef POLY_EVAL_RETAIN_EN
        test_retain();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
